audio_deserializer: RTL and testbench
=====================================

Name: audio_deserializer

Overview:
- Receive-side counterpart of the 16-bit audio serializer.
- Samples a 1-bit serial stream, MSB first, one bit per accepted strobe, and reassembles WIDTH-bit words.
- Presents each completed word on a one-deep valid/ready holding register for the downstream memory writer.
- Flags an overrun when an unconsumed word is overwritten.

Parameters:
WIDTH, 16, word length in bits (>= 2)
SYNC_WORD, 16'hA5A5, framing pattern; used only when DESER_SYNC_HUNT_EN is defined

Ports:
clock  input  1  system clock, all state updates on posedge
reset  input  1  asynchronous, active-high; clears all state immediately
enable  input  1  block enable; low aborts any partial word
bit_valid  input  1  strobe: bit_in is a valid serial bit this cycle
bit_in  input  1  serial data bit, MSB of each word first
data_out  output  WIDTH  last completed word
data_valid  output  1  data_out holds an unconsumed word
data_ready  input  1  downstream accepts data_out this cycle
overrun  output  1  sticky: a completed word overwrote an unconsumed one
locked  output  1  1 while in SHIFT state
bit_count  output  $clog2(WIDTH)  bits received in current word

Behaviour:
- Reset values (async assert): state IDLE, shift register 0, bit_count 0, data_out 0, data_valid 0, overrun 0, locked 0.
- States: IDLE, SHIFT (plus HUNT with the macro). Registered state.
- IDLE: bit_valid ignored. Next edge with enable=1 moves to SHIFT, or to HUNT with the macro.
  - The first bit accepted is therefore the one in the cycle after enable rises, matching the serializer's one-cycle startup delay.
- Any state with enable=0: next edge goes to IDLE and clears the shift register and bit_count.
  - data_out, data_valid and overrun are retained, so a pending word can still be taken.
- SHIFT, on enable && bit_valid:
  - shift register <= {shift[WIDTH-2:0], bit_in}.
  - bit_count increments.
  - When bit_count == WIDTH-1, the word is complete at this edge:
    - data_out <= {shift[WIDTH-2:0], bit_in}.
    - data_valid <= 1.
    - bit_count wraps to 0.
    - The shift register needs no clear.
- Latency: data_valid and the new data_out are visible in the cycle after the WIDTH-th bit is sampled.
- Cycles with bit_valid=0 hold all shift state (gaps allowed anywhere in a word).
- Handshake: transfer occurs at an edge with data_valid && data_ready.
  - data_valid clears at that edge unless a word completes at the same edge.
  - If a word completes at the same edge, data_out takes the new word and data_valid stays 1, with no overrun.
- Overrun: a word completes while data_valid=1 && data_ready=0.
  - data_out is overwritten with the new word.
  - data_valid stays 1.
  - overrun <= 1 and stays set until reset.
- data_ready with data_valid=0 has no effect.
- locked = (state == SHIFT).

Optional Feature:
DESER_SYNC_HUNT_EN
- Defined: enabling enters HUNT instead of SHIFT.
  - In HUNT, each accepted bit shifts into the shift register; bit_count stays 0 and nothing is output.
  - When {shift[WIDTH-2:0], bit_in} == SYNC_WORD, go to SHIFT at that edge with the shift register cleared and bit_count 0.
  - The sync word itself is never output.
  - Dropping enable returns to IDLE, and re-enabling hunts again.
- Undefined: no HUNT state and SYNC_WORD is unused. IDLE goes directly to SHIFT; locked=1 whenever in SHIFT.

Test Plan:
- Reset, enable=1, data_ready=1, 16 consecutive bit_valid bits of 16'hBEEF MSB first -> data_out=16'hBEEF, data_valid=1 exactly one cycle after the 16th bit, cleared the next cycle, overrun=0.
- Back-to-back words 16'h1234 then 16'h5678 with data_ready=1 and bit_valid toggling every other cycle -> two single-word transfers in order, bit_count wraps 15->0, overrun=0.
- data_ready=0, words 16'h1234 then 16'h5678 -> data_out=16'h5678, data_valid=1, overrun=1; then data_ready=1 -> data_valid=0, overrun stays 1.
- Send 5 bits, drop enable one cycle, re-enable, send 16'h00FF -> single word 16'h00FF, partial bits discarded; then assert reset mid-word -> all outputs 0 immediately, asynchronously.
- Simultaneous: data_valid=1 with data_ready=1 on the edge where the next word completes -> data_out updates to the new word, data_valid stays 1, overrun=0.
- With DESER_SYNC_HUNT_EN: bits 3'b101, then 16'hA5A5, then 16'hCAFE -> locked rises after the sync word, only 16'hCAFE is output, and 16'hA5A5 never appears on data_out.

Source files
------------

// File: rtl/audio_deserializer.sv
// -----------------------------------------------------------------------------
// audio_deserializer
//
// Receive-side counterpart of the audio serializer. It samples a 1-bit serial
// stream, MSB first, taking one bit on every cycle where bit_valid is high. It
// reassembles WIDTH-bit words and places each finished word in a one-deep
// valid/ready holding register that feeds the downstream memory writer.
//
// Optional feature (compile-time macro):
//   DESER_SYNC_HUNT_EN - when defined, enabling the block enters a HUNT state.
//                        The block only starts assembling words after it sees
//                        SYNC_WORD in the incoming stream. The sync word itself
//                        is never output. When the macro is undefined, the
//                        block goes from IDLE straight to SHIFT and SYNC_WORD
//                        is not used.
//
// Parameters:
//   WIDTH      word length in bits (>= 2)
//   SYNC_WORD  framing pattern (only used with DESER_SYNC_HUNT_EN)
//
// Ports:
//   clock       in   1            system clock, all state updates on posedge
//   reset       in   1            asynchronous active-high reset
//   enable      in   1            block enable; low aborts any partial word
//   bit_valid   in   1            bit_in carries a valid serial bit this cycle
//   bit_in      in   1            serial data bit, MSB of each word first
//   data_out    out  WIDTH        last completed word
//   data_valid  out  1            data_out holds an unconsumed word
//   data_ready  in   1            downstream accepts data_out this cycle
//   overrun     out  1            sticky: a completed word overwrote a pending one
//   locked      out  1            high while in SHIFT state
//   bit_count   out  clog2(WIDTH) bits received in the current word
// -----------------------------------------------------------------------------
module audio_deserializer #(
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] SYNC_WORD = 16'hA5A5
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     bit_valid,
    input  logic                     bit_in,
    output logic [WIDTH-1:0]         data_out,
    output logic                     data_valid,
    input  logic                     data_ready,
    output logic                     overrun,
    output logic                     locked,
    output logic [$clog2(WIDTH)-1:0] bit_count
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HUNT  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_next;
    logic [WIDTH-1:0]   w_shift_cat;
    logic [CNT_W-1:0]   r_bit_count;
    logic [CNT_W-1:0]   w_count_next;
    logic               w_word_done;
    logic [WIDTH-1:0]   r_data_out;
    logic [WIDTH-1:0]   w_data_next;
    logic               r_data_valid;
    logic               w_valid_next;
    logic               r_overrun;
    logic               w_overrun_next;
    logic               r_locked;

    // Shift register contents after accepting bit_in this cycle; this is also
    // the completed word on the last bit.
    assign w_shift_cat = {r_shift[WIDTH-2:0], bit_in};

`ifdef DESER_SYNC_HUNT_EN
    logic w_sync_hit;
    assign w_sync_hit = (w_shift_cat == SYNC_WORD);
`else
    logic w_unused_sync;
    assign w_unused_sync = ^SYNC_WORD;
`endif

    // Next-state selection; dropping enable always falls back to IDLE
    always_comb begin
        w_state_next = r_state;
        if (!enable) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef DESER_SYNC_HUNT_EN
                    w_state_next = ST_HUNT;
`else
                    w_state_next = ST_SHIFT;
`endif
                end
                ST_SHIFT: begin
                    w_state_next = ST_SHIFT;
                end
`ifdef DESER_SYNC_HUNT_EN
                ST_HUNT: begin
                    if (bit_valid && w_sync_hit) begin
                        w_state_next = ST_SHIFT;
                    end else begin
                        w_state_next = ST_HUNT;
                    end
                end
`endif
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Shift register / bit counter update and word-completion detect
    always_comb begin
        w_shift_next = r_shift;
        w_count_next = r_bit_count;
        w_word_done  = 1'b0;
        if (!enable) begin
            w_shift_next = '0;
            w_count_next = '0;
        end else if (bit_valid) begin
            case (r_state)
                ST_SHIFT: begin
                    w_shift_next = w_shift_cat;
                    if (r_bit_count == LAST_BIT) begin
                        // No need to clear the shift register: the next
                        // WIDTH bits push every old bit out.
                        w_count_next = '0;
                        w_word_done  = 1'b1;
                    end else begin
                        w_count_next = r_bit_count + CNT_ONE;
                    end
                end
`ifdef DESER_SYNC_HUNT_EN
                ST_HUNT: begin
                    w_count_next = '0;
                    if (w_sync_hit) begin
                        w_shift_next = '0;
                    end else begin
                        w_shift_next = w_shift_cat;
                    end
                end
`endif
                default: begin
                    // IDLE ignores bit_valid
                    w_shift_next = r_shift;
                    w_count_next = r_bit_count;
                end
            endcase
        end else begin
            w_shift_next = r_shift;
            w_count_next = r_bit_count;
        end
    end

    // Holding register: a newly completed word beats a same-edge transfer.
    // These registers ignore enable so a pending word can still be taken.
    always_comb begin
        w_data_next    = r_data_out;
        w_valid_next   = r_data_valid;
        w_overrun_next = r_overrun;
        if (w_word_done) begin
            w_data_next  = w_shift_cat;
            w_valid_next = 1'b1;
            if (r_data_valid && !data_ready) begin
                w_overrun_next = 1'b1;
            end else begin
                w_overrun_next = r_overrun;
            end
        end else if (r_data_valid && data_ready) begin
            w_valid_next = 1'b0;
        end else begin
            w_valid_next = r_data_valid;
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_bit_count  <= '0;
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_shift      <= w_shift_next;
            r_bit_count  <= w_count_next;
            r_data_out   <= w_data_next;
            r_data_valid <= w_valid_next;
            r_overrun    <= w_overrun_next;
            // Registered copy of (state == SHIFT), tracked alongside r_state
            r_locked     <= (w_state_next == ST_SHIFT);
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign overrun    = r_overrun;
    assign locked     = r_locked;
    assign bit_count  = r_bit_count;

endmodule

// File: tb/tb_audio_deserializer.sv
module tb_audio_deserializer;

    localparam int               WIDTH = 16;
    localparam logic [WIDTH-1:0] SYNC  = 16'hA5A5;
`ifdef DESER_SYNC_HUNT_EN
    localparam bit HUNT_EN = 1'b1;
`else
    localparam bit HUNT_EN = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic             enable;
    logic             bit_valid;
    logic             bit_in;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic             data_ready;
    logic             overrun;
    logic             locked;
    logic [3:0]       bit_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    audio_deserializer #(.WIDTH(WIDTH), .SYNC_WORD(SYNC)) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .bit_valid  (bit_valid),
        .bit_in     (bit_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun),
        .locked     (locked),
        .bit_count  (bit_count)
    );

    always #5 clock = ~clock;

    // Reference model: bits gathered since the block became active, plus the
    // holding-register view seen by the downstream writer.
    bit               m_q[$];
    bit               m_active;
    bit               m_hunt;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ovr;

    function automatic logic [WIDTH-1:0] q_value();
        logic [WIDTH-1:0] v = '0;
        foreach (m_q[i]) v = {v[WIDTH-2:0], m_q[i]};
        return v;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_hunt   = 1'b0;
        m_data   = '0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
    endtask

    task automatic model_edge(input logic en, input logic bv, input logic b, input logic rdy);
        bit               done = 1'b0;
        logic [WIDTH-1:0] word = '0;
        if (!en) begin
            m_q.delete();
            m_active = 1'b0;
            m_hunt   = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_hunt   = HUNT_EN;
            m_q.delete();
        end else if (bv) begin
            m_q.push_back(b);
            if (m_hunt) begin
                if (m_q.size() > WIDTH) void'(m_q.pop_front());
                if (q_value() == SYNC) begin
                    m_hunt = 1'b0;
                    m_q.delete();
                end
            end else if (m_q.size() == WIDTH) begin
                done = 1'b1;
                word = q_value();
                m_q.delete();
            end
        end
        if (done) begin
            if (m_valid && !rdy) m_ovr = 1'b1;
            m_data  = word;
            m_valid = 1'b1;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".data_out"},   32'(data_out),   32'(m_data));
        chk({tag, ".data_valid"}, 32'(data_valid), 32'(m_valid));
        chk({tag, ".overrun"},    32'(overrun),    32'(m_ovr));
        chk({tag, ".locked"},     32'(locked),     32'(m_active && !m_hunt));
        chk({tag, ".bit_count"},  32'(bit_count),  (m_hunt ? 32'd0 : 32'(m_q.size())));
    endtask

    task automatic step(input string tag, input logic en, input logic bv, input logic b, input logic rdy);
        enable     = en;
        bit_valid  = bv;
        bit_in     = b;
        data_ready = rdy;
        @(posedge clock);
        model_edge(en, bv, b, rdy);
        #1;
        check_all(tag);
    endtask

    task automatic send_word(input string tag, input logic [WIDTH-1:0] w, input logic rdy, input bit gaps);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (gaps) step(tag, 1'b1, 1'b0, 1'($urandom_range(0, 1)), rdy);
            step(tag, 1'b1, 1'b1, w[i], rdy);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] w;
        reset      = 1'b1;
        enable     = 1'b0;
        bit_valid  = 1'b0;
        bit_in     = 1'b0;
        data_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        chk("rst.data_out",   32'(data_out),   32'd0);
        chk("rst.data_valid", 32'(data_valid), 32'd0);
        chk("rst.overrun",    32'(overrun),    32'd0);
        chk("rst.locked",     32'(locked),     32'd0);
        chk("rst.bit_count",  32'(bit_count),  32'd0);

`ifdef DESER_SYNC_HUNT_EN
        // Hunt for the sync word, then receive one real word
        step("hunt_en", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("hunt.locked_pre", 32'(locked), 32'd0);
        w = 16'h0005;
        for (int i = 2; i >= 0; i--) step("hunt_pre", 1'b1, 1'b1, w[i], 1'b1);
        send_word("hunt_sync", SYNC, 1'b1, 1'b0);
        chk("hunt.locked_post", 32'(locked), 32'd1);
        chk("hunt.no_sync_out", 32'(data_valid), 32'd0);
        send_word("hunt_word", 16'hCAFE, 1'b1, 1'b0);
        chk("hunt.cafe_data",  32'(data_out),   32'h0000CAFE);
        chk("hunt.cafe_valid", 32'(data_valid), 32'd1);
        step("hunt_drain", 1'b1, 1'b0, 1'b0, 1'b1);
`else
        // Single word with the consumer always ready
        step("beef_en", 1'b1, 1'b0, 1'b0, 1'b1);
        send_word("beef", 16'hBEEF, 1'b1, 1'b0);
        chk("beef.data",    32'(data_out),   32'h0000BEEF);
        chk("beef.valid",   32'(data_valid), 32'd1);
        step("beef_drain", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("beef.cleared", 32'(data_valid), 32'd0);
        chk("beef.overrun", 32'(overrun),    32'd0);

        // Back-to-back words with bit_valid toggling
        send_word("b2b_a", 16'h1234, 1'b1, 1'b1);
        chk("b2b.first", 32'(data_out), 32'h00001234);
        send_word("b2b_b", 16'h5678, 1'b1, 1'b1);
        chk("b2b.second", 32'(data_out), 32'h00005678);
        step("b2b_drain", 1'b1, 1'b0, 1'b0, 1'b1);

        // Overrun with the consumer stalled
        send_word("ovr_a", 16'h1234, 1'b0, 1'b0);
        send_word("ovr_b", 16'h5678, 1'b0, 1'b0);
        chk("ovr.data",    32'(data_out), 32'h00005678);
        chk("ovr.overrun", 32'(overrun),  32'd1);
        step("ovr_take", 1'b1, 1'b0, 1'b0, 1'b1);
        chk("ovr.taken",  32'(data_valid), 32'd0);
        chk("ovr.sticky", 32'(overrun),    32'd1);

        // Partial word aborted by dropping enable
        for (int i = 0; i < 5; i++) step("abort_bits", 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
        step("abort_off", 1'b0, 1'b1, 1'b1, 1'b1);
        step("abort_on",  1'b1, 1'b1, 1'b1, 1'b1);
        send_word("abort_word", 16'h00FF, 1'b1, 1'b0);
        chk("abort.data", 32'(data_out), 32'h000000FF);

        // Asynchronous reset in the middle of a word
        for (int i = 0; i < 3; i++) step("arst_bits", 1'b1, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst.data_out",   32'(data_out),   32'd0);
        chk("arst.data_valid", 32'(data_valid), 32'd0);
        chk("arst.overrun",    32'(overrun),    32'd0);
        chk("arst.locked",     32'(locked),     32'd0);
        chk("arst.bit_count",  32'(bit_count),  32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Transfer and completion on the same edge
        step("sim_en", 1'b1, 1'b0, 1'b0, 1'b0);
        send_word("sim_a", 16'hAAAA, 1'b0, 1'b0);
        w = 16'h3C3C;
        for (int i = WIDTH - 1; i >= 0; i--) step("sim_b", 1'b1, 1'b1, w[i], 1'(i == 0));
        chk("sim.data",    32'(data_out),   32'h00003C3C);
        chk("sim.valid",   32'(data_valid), 32'd1);
        chk("sim.overrun", 32'(overrun),    32'd0);
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step("rand", 1'($urandom_range(0, 19) != 0), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
